// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit scheduler: FSM state encoding,
// FX2 FIFOADR endpoint codes and the post-packet holdoff length.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADR_SETUP,
    WRITE,
    PKTEND,
    HOLDOFF
  } tx_state_e;

  localparam logic [1:0] EP2_ADR = 2'b00;
  localparam logic [1:0] EP4_ADR = 2'b01;
  localparam logic [1:0] EP6_ADR = 2'b10;
  localparam logic [1:0] EP8_ADR = 2'b11;

  // FX2 flags lag a commit by a couple of IFCLKs; keep the port owned that long.
  localparam int HOLDOFF_CYC = 2;

endpackage

// File: rtl/usb_tx_scheduler_if.sv
// Bundle between the upstream cs/data FWFT FIFOs, the scheduler and the FX2 slave-FIFO port.
// master = scheduler side, slave = FIFOs / slave-FIFO I/O block side.
interface usb_tx_scheduler_if;
  import usb_tx_pkg::*;

  logic        cs_empty;
  logic [15:0] cs_dout;
  logic        cs_re;
  logic        data_empty;
  logic [15:0] data_dout;
  logic        data_re;
  logic        sl_cs_full;
  logic        sl_data_full;
  logic        sl_wr;
  logic [15:0] sl_wr_data;
  logic        sl_pktend;
  logic [1:0]  sl_fifo_adr;
  logic        tx_active;
  logic        tx_grant;

  modport master (
    input  cs_empty, cs_dout, data_empty, data_dout, sl_cs_full, sl_data_full,
    output cs_re, data_re, sl_wr, sl_wr_data, sl_pktend, sl_fifo_adr, tx_active, tx_grant
  );

  modport slave (
    output cs_empty, cs_dout, data_empty, data_dout, sl_cs_full, sl_data_full,
    input  cs_re, data_re, sl_wr, sl_wr_data, sl_pktend, sl_fifo_adr, tx_active, tx_grant
  );

endinterface

// File: rtl/usb_tx_arbiter.sv
// cs/data grant for the shared slave-FIFO port: cs has priority, but after
// MAX_CS_BURST consecutive cs packets a waiting data source gets one packet.
module usb_tx_arbiter #(
  parameter int MAX_CS_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_empty,
  input  logic cs_full,
  input  logic data_empty,
  input  logic data_full,
  input  logic arb_en,
  input  logic pkt_done,
  input  logic pkt_src,
  output logic grant_valid,
  output logic grant_data
);

  localparam int BW = $clog2(MAX_CS_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_CS_BURST);

  logic [BW-1:0] cs_burst_q;
  logic          cs_cand;
  logic          data_cand;

  assign cs_cand     = !cs_empty && !cs_full;
  assign data_cand   = !data_empty && !data_full;
  assign grant_valid = cs_cand || data_cand;
  assign grant_data  = data_cand && (!cs_cand || (cs_burst_q == BURST_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_burst_q <= '0;
    end else if (pkt_done) begin
      if (pkt_src) begin
        cs_burst_q <= '0;
      end else if (cs_burst_q != BURST_MAX) begin
        cs_burst_q <= cs_burst_q + 1'b1;
      end
    end else if (arb_en && data_empty) begin
      // Nobody is starved when data has nothing to send.
      cs_burst_q <= '0;
    end
  end

endmodule

// File: rtl/usb_tx_scheduler.sv
// Packetising arbiter onto the FX2 slave-FIFO write port (IFCLK domain).
// Build option: USB_TX_STATS_EN adds cs/data/short packet counters for debug cores.
//
// state     | meaning
// IDLE      | port free, arbitrate between cs and data
// ADR_SETUP | FIFOADR driven, one cycle for address and flags to settle
// WRITE     | stream words of the granted source, count idle cycles while empty
// PKTEND    | one-cycle PKTEND strobe to commit a short packet
// HOLDOFF   | port still owned while FX2 flags catch up
module usb_tx_scheduler
  import usb_tx_pkg::*;
#(
  parameter int         PKT_WORDS    = 256,
  parameter int         TIMEOUT_CYC  = 1024,
  parameter int         MAX_CS_BURST = 4,
  parameter logic [1:0] CS_ADR       = EP8_ADR,
  parameter logic [1:0] DATA_ADR     = EP6_ADR
) (
  input  logic               clk,
  input  logic               rst_n,
  usb_tx_scheduler_if.master bus
`ifdef USB_TX_STATS_EN
  ,
  output logic [15:0]        cs_pkt_cnt,
  output logic [15:0]        data_pkt_cnt,
  output logic [15:0]        short_pkt_cnt
`endif
);

  localparam int WCW = $clog2(PKT_WORDS + 1);
  localparam int IW  = $clog2(TIMEOUT_CYC + 1);
  localparam int HW  = $clog2(HOLDOFF_CYC + 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(PKT_WORDS - 1);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(TIMEOUT_CYC - 1);
  localparam logic [IW-1:0]  IDLE_MAX  = IW'(TIMEOUT_CYC);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLDOFF_CYC - 1);

  tx_state_e      state_q, state_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [IW-1:0]  idle_q, idle_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           tx_grant_q;
  logic           tx_active_q;
  logic           sl_wr_q;
  logic [15:0]    sl_wr_data_q;
  logic           sl_pktend_q;
  logic [1:0]     sl_fifo_adr_q;

  logic           src_empty;
  logic           src_full;
  logic [15:0]    src_dout;
  logic           pop;
  logic           arb_en;
  logic           arb_valid;
  logic           arb_grant_data;
  logic           pkt_done;

  usb_tx_arbiter #(
    .MAX_CS_BURST (MAX_CS_BURST)
  ) u_arbiter (
    .clk         (clk),
    .rst_n       (rst_n),
    .cs_empty    (bus.cs_empty),
    .cs_full     (bus.sl_cs_full),
    .data_empty  (bus.data_empty),
    .data_full   (bus.sl_data_full),
    .arb_en      (arb_en),
    .pkt_done    (pkt_done),
    .pkt_src     (tx_grant_q),
    .grant_valid (arb_valid),
    .grant_data  (arb_grant_data)
  );

  assign src_empty = tx_grant_q ? bus.data_empty   : bus.cs_empty;
  assign src_full  = tx_grant_q ? bus.sl_data_full : bus.sl_cs_full;
  assign src_dout  = tx_grant_q ? bus.data_dout    : bus.cs_dout;
  assign pop       = (state_q == WRITE) && !src_empty && !src_full;
  assign arb_en    = (state_q == IDLE);

  // Pop is combinational so the FWFT head word is captured on the same edge.
  assign bus.cs_re   = pop && !tx_grant_q;
  assign bus.data_re = pop && tx_grant_q;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    idle_d     = idle_q;
    hold_d     = hold_q;
    pkt_done   = 1'b0;
    case (state_q)
      IDLE: begin
        word_cnt_d = '0;
        idle_d     = '0;
        hold_d     = '0;
        if (arb_valid) state_d = ADR_SETUP;
      end
      ADR_SETUP: begin
        state_d = WRITE;
      end
      WRITE: begin
        hold_d = '0;
        if (pop) begin
          word_cnt_d = word_cnt_q + 1'b1;
          idle_d     = '0;
          if (word_cnt_q == WORD_LAST) begin
            state_d  = HOLDOFF;
            pkt_done = 1'b1;
          end
        end else if (src_empty && !src_full) begin
          // A full endpoint stalls the packet without counting towards the timeout.
          if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
          if (idle_q >= IDLE_LAST) begin
            state_d = (word_cnt_q != '0) ? PKTEND : HOLDOFF;
          end
        end
      end
      PKTEND: begin
        hold_d   = '0;
        pkt_done = 1'b1;
        state_d  = HOLDOFF;
      end
      HOLDOFF: begin
        if (hold_q == HOLD_LAST) begin
          state_d    = IDLE;
          word_cnt_d = '0;
          idle_d     = '0;
          hold_d     = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      word_cnt_q    <= '0;
      idle_q        <= '0;
      hold_q        <= '0;
      tx_grant_q    <= 1'b0;
      tx_active_q   <= 1'b0;
      sl_wr_q       <= 1'b0;
      sl_wr_data_q  <= '0;
      sl_pktend_q   <= 1'b0;
      sl_fifo_adr_q <= CS_ADR;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      idle_q      <= idle_d;
      hold_q      <= hold_d;
      tx_active_q <= (state_d != IDLE);
      sl_wr_q     <= pop;
      sl_pktend_q <= (state_d == PKTEND);
      if (pop) sl_wr_data_q <= src_dout;
      // FIFOADR only moves on the way into ADR_SETUP.
      if (arb_en && arb_valid) begin
        tx_grant_q    <= arb_grant_data;
        sl_fifo_adr_q <= arb_grant_data ? DATA_ADR : CS_ADR;
      end
    end
  end

  assign bus.sl_wr       = sl_wr_q;
  assign bus.sl_wr_data  = sl_wr_data_q;
  assign bus.sl_pktend   = sl_pktend_q;
  assign bus.sl_fifo_adr = sl_fifo_adr_q;
  assign bus.tx_active   = tx_active_q;
  assign bus.tx_grant    = tx_grant_q;

`ifdef USB_TX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_pkt_cnt    <= '0;
      data_pkt_cnt  <= '0;
      short_pkt_cnt <= '0;
    end else begin
      if (pkt_done && tx_grant_q)  data_pkt_cnt  <= data_pkt_cnt + 1'b1;
      if (pkt_done && !tx_grant_q) cs_pkt_cnt    <= cs_pkt_cnt + 1'b1;
      if (state_q == PKTEND)       short_pkt_cnt <= short_pkt_cnt + 1'b1;
    end
  end
`endif

endmodule
